// File: rtl/bit_alloc_pool_pkg.sv
// bit_alloc_pool_pkg: constants shared by the free-list allocator.
package bit_alloc_pool_pkg;
   localparam int BIT_ALLOC_MAX_CH = 8;
endpackage

// File: rtl/bit_alloc_pool_find.sv
// bit_find_nth_bit: one-hot N-th set bit of a mask,
// counted from bit 0 or, with FROM_TOP, from the MSB.
module bit_find_nth_bit #(
   parameter int WIDTH    = 32,
   parameter int N        = 0,
   parameter bit FROM_TOP = 1'b0
) (
   input  logic [WIDTH-1:0] mask_i,
   output logic [WIDTH-1:0] onehot_o,
   output logic             found_o
);
   always_comb begin
      int seen;
      int idx;
      onehot_o = '0;
      found_o  = 1'b0;
      seen     = 0;
      idx      = 0;
      for (int i = 0; i < WIDTH; i++) begin
         idx = FROM_TOP ? (WIDTH - 1 - i) : i;
         if (mask_i[idx]) begin
            if (seen == N) begin
               onehot_o[idx] = 1'b1;
               found_o       = 1'b1;
            end
            seen = seen + 1;
         end
      end
   end
endmodule

// File: rtl/bit_alloc_pool.sv
// bit_alloc_pool: registered free-list allocator, NALLOC grants per cycle.
// Define BIT_ALLOC_POOL_CHECK_EN to add the sticky dblFree output.
module bit_alloc_pool
   import bit_alloc_pool_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               NALLOC    = 4,
   parameter logic [WIDTH-1:0] INIT_FREE = {WIDTH{1'b1}},
   localparam int              CW        = $clog2(WIDTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clkEn,
   input  logic [NALLOC-1:0]       needed,
   output logic [NALLOC*WIDTH-1:0] bitsOut,
   output logic                    doStall,
   input  logic [WIDTH-1:0]        freeBits,
   output logic [WIDTH-1:0]        freeMask,
   output logic [CW-1:0]           freeCount,
   output logic                    empty
`ifdef BIT_ALLOC_POOL_CHECK_EN
   ,
   output logic                    dblFree
`endif
);
   if (NALLOC < 1 || NALLOC > BIT_ALLOC_MAX_CH) begin : g_bad_nalloc
      $error("bit_alloc_pool: NALLOC out of range");
   end

   function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] m);
      popcnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         popcnt = popcnt + CW'(m[i]);
      end
   endfunction

   logic [WIDTH-1:0]  mask_q;
   logic [WIDTH-1:0]  mask_d;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic              empty_q;
   logic [WIDTH-1:0]  pick [NALLOC];
   logic [NALLOC-1:0] found;
   logic [WIDTH-1:0]  grant_or;
   logic              go;
   int                req_top;

   always_comb begin
      req_top = 0;
      for (int i = 0; i < NALLOC; i++) begin
         if (needed[i]) req_top = i + 1;
      end
   end

   // Stall covers the highest requested channel so slot mapping holds.
   assign doStall = clkEn & (int'(cnt_q) < req_top);
   assign go      = clkEn & ~doStall;

   for (genvar k = 0; k < NALLOC; k++) begin : g_ch
      bit_find_nth_bit #(
         .WIDTH   (WIDTH),
         .N       (k / 2),
         .FROM_TOP(k % 2 == 1)
      ) u_find (
         .mask_i  (mask_q),
         .onehot_o(pick[k]),
         .found_o (found[k])
      );
      assign bitsOut[k*WIDTH +: WIDTH] =
         pick[k] & {WIDTH{go & needed[k] & found[k]}};
   end

   always_comb begin
      grant_or = '0;
      for (int k = 0; k < NALLOC; k++) begin
         grant_or = grant_or | bitsOut[k*WIDTH +: WIDTH];
      end
   end

   assign mask_d = (mask_q & ~grant_or) | freeBits;
   assign cnt_d  = popcnt(mask_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q  <= INIT_FREE;
         cnt_q   <= popcnt(INIT_FREE);
         empty_q <= (popcnt(INIT_FREE) == '0);
      end else begin
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         empty_q <= (cnt_d == '0);
      end
   end

   assign freeMask  = mask_q;
   assign freeCount = cnt_q;
   assign empty     = empty_q;

`ifdef BIT_ALLOC_POOL_CHECK_EN
   logic dbl_q;
   logic dbl_hit;

   assign dbl_hit = |(freeBits & (mask_q | grant_or));

   always_ff @(posedge clk) begin
      if (rst) begin
         dbl_q <= 1'b0;
      end else if (dbl_hit) begin
         dbl_q <= 1'b1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst && dbl_hit && !dbl_q) begin
         $display("bit_alloc_pool: double free %h", freeBits);
      end
   end
`endif

   assign dblFree = dbl_q;
`endif
endmodule
